clk_gate_ctrl: RTL and testbench
================================

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter WAKE_CYC, default 4, meaning the number of settle cycles between en_o rising and ack_o rising (range 1..255).
REQ-002 SHALL have parameter IDLE_W, default 8, meaning the width of the idle counter and of idle_limit_i.
REQ-003 SHALL have port clk_inv_net, input, 1 bit: the block clock; all state updates on its rising edge.
REQ-004 SHALL have port arstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req_i, input, 1 bit: level request for the gated clock to be on.
REQ-006 SHALL have port force_on_i, input, 1 bit: holds the clock on and disables auto-gating.
REQ-007 SHALL have port busy_i, input, 1 bit: activity flag from the clocked domain.
REQ-008 SHALL have port idle_limit_i, input, IDLE_W bits: consecutive idle cycles before auto-gating; 0 disables auto-gating.
REQ-009 SHALL have port en_o, input-to-gate enable, output, 1 bit: drives the downstream clock gate enable.
REQ-010 SHALL have port ack_o, output, 1 bit: high only when the gated clock is on and settled.
REQ-011 SHALL have port state_o, output, 2 bits: current state (OFF=0, WAKE=1, ON=2, DRAIN=3).

Function
REQ-012 SHALL be a registered Moore FSM with states OFF, WAKE, ON and DRAIN; all outputs SHALL be decoded from registered state only.
REQ-013 en_o SHALL be 0 in OFF and 1 in WAKE, ON and DRAIN; ack_o SHALL be 1 only in ON.
REQ-014 OFF->WAKE SHALL occur on the edge where force_on_i=1, or req_i=1 with asleep=0, or req_i=1 with busy_i=1; wake counter SHALL load WAKE_CYC-1.
REQ-015 In WAKE, the counter SHALL decrement each edge; WAKE->ON SHALL occur on the edge where counter=0, independent of req_i, so WAKE always lasts exactly WAKE_CYC cycles.
REQ-016 In ON, the idle counter SHALL clear on any edge with busy_i=1 or force_on_i=1, SHALL increment on edges with busy_i=0, and SHALL saturate at all-ones.
REQ-017 ON->DRAIN SHALL occur when force_on_i=0 and either req_i=0 (manual) or idle_limit_i!=0 with the idle counter reaching idle_limit_i (auto); auto SHALL set asleep=1.
REQ-018 With both exit conditions true on the same edge, the transition SHALL be treated as manual (asleep stays 0).
REQ-019 DRAIN->OFF SHALL occur on the first edge with busy_i=0; DRAIN->ON SHALL occur if force_on_i=1, and takes priority.
REQ-020 asleep SHALL clear on OFF->WAKE and on any edge with req_i=0.
REQ-021 The idle counter SHALL clear on every entry into ON.
REQ-022 Parameter or input changes to idle_limit_i mid-ON SHALL take effect on the next edge compare.

Reset
REQ-023 On arstn_i=0, state SHALL go to OFF immediately (asynchronously), with en_o=0, ack_o=0, state_o=0, both counters 0 and asleep=0, including mid-WAKE/ON/DRAIN.
REQ-024 After reset release, the first transition SHALL follow REQ-014 on the first rising clk_inv_net edge.

Structure
REQ-025 The state typedef gate_state_e and the default values of WAKE_CYC and IDLE_W SHALL live in shared package crg_pkg.
REQ-026 The idle counter with clear/increment/saturate and compare-to-limit SHALL be sub-module clk_idle_cnt; the FSM and wake counter SHALL remain in clk_gate_ctrl.

Verification
REQ-027 Bench SHALL run a wake scenario: WAKE_CYC=4, req_i 0->1 at edge 0 -> en_o=1 after edge 0, state_o=1 for 4 cycles, ack_o=1 after edge 4.
REQ-028 Bench SHALL run a manual off scenario: in ON, req_i->0 with busy_i=1 for 3 cycles then 0 -> ack_o drops after next edge, DRAIN held 3 cycles, en_o=0 one edge after busy_i falls.
REQ-029 Bench SHALL run an auto-gate scenario: idle_limit_i=5, req_i=1, busy_i=0 -> DRAIN after 5th idle edge, OFF next edge, stays OFF with req_i=1; busy_i pulse -> WAKE next edge.
REQ-030 Bench SHALL run a force-on scenario: force_on_i=1 with idle_limit_i=2, busy_i=0 for 20 cycles -> remains ON, ack_o=1 throughout; force_on_i=1 in DRAIN -> ON next edge.
REQ-031 Bench SHALL run a reset scenario: arstn_i low mid-WAKE (counter=2) and mid-ON -> en_o, ack_o, state_o=0 without a clock edge; wake after release takes full WAKE_CYC.
REQ-032 Bench SHALL run an idle_limit_i=0 scenario: busy_i=0 for 300 cycles -> no auto-gating, idle counter saturates at 255, no wrap.

Source files
------------

// File: rtl/crg_pkg.sv
// crg_pkg: shared clock-gate state encoding and parameter defaults
package crg_pkg;
  typedef enum logic [1:0] {GS_OFF = 2'd0, GS_WAKE = 2'd1, GS_ON = 2'd2, GS_DRAIN = 2'd3} gate_state_e;
  localparam int WAKE_CYC_DEF = 4;
  localparam int IDLE_W_DEF = 8;
endpackage

// File: rtl/clk_idle_cnt.sv
// clk_idle_cnt: saturating idle counter with compare-to-limit for auto-gating
module clk_idle_cnt import crg_pkg::*; #(
  parameter int W = IDLE_W_DEF
) (
  input  logic         clk_inv_net,
  input  logic         arstn_i,
  input  logic         run,
  input  logic         busy,
  input  logic         force_on,
  input  logic [W-1:0] limit,
  output logic         hit
);
  logic [W-1:0] cnt, inc;
  // hit looks at the value this edge would load, so limit N gates on the Nth idle edge
  always_comb begin
    inc = &cnt ? cnt : cnt + 1'b1;
    hit = run && |limit && !busy && !force_on && inc >= limit;
  end
  always_ff @(posedge clk_inv_net or negedge arstn_i)
    if (!arstn_i) cnt <= '0;
    else cnt <= (!run || busy || force_on) ? '0 : inc;
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: Moore FSM sequencing a downstream clock gate with wake settle and idle auto-gating
module clk_gate_ctrl import crg_pkg::*; #(
  parameter int WAKE_CYC = WAKE_CYC_DEF,
  parameter int IDLE_W   = IDLE_W_DEF
) (
  input  logic              clk_inv_net,
  input  logic              arstn_i,
  input  logic              req_i,
  input  logic              force_on_i,
  input  logic              busy_i,
  input  logic [IDLE_W-1:0] idle_limit_i,
  output logic              en_o,
  output logic              ack_o,
  output logic [1:0]        state_o
);
  gate_state_e state, state_nx;
  logic [7:0] wake_cnt, wake_cnt_nx;
  logic asleep, asleep_nx, wake_go, man_exit, auto_exit, hit;
  clk_idle_cnt #(.W(IDLE_W)) u_idle (
    .clk_inv_net(clk_inv_net),
    .arstn_i    (arstn_i),
    .run        (state == GS_ON),
    .busy       (busy_i),
    .force_on   (force_on_i),
    .limit      (idle_limit_i),
    .hit        (hit)
  );
  // manual exit wins over auto so a dropped request never leaves asleep set
  always_comb begin
    wake_go = force_on_i || (req_i && (!asleep || busy_i));
    man_exit = state == GS_ON && !force_on_i && !req_i;
    auto_exit = state == GS_ON && !man_exit && hit;
    state_nx = state;
    wake_cnt_nx = wake_cnt;
    case (state)
      GS_OFF: if (wake_go) begin
        state_nx = GS_WAKE;
        wake_cnt_nx = 8'(WAKE_CYC - 1);
      end
      GS_WAKE: if (wake_cnt == 8'd0) state_nx = GS_ON;
               else wake_cnt_nx = wake_cnt - 1'b1;
      GS_ON: if (man_exit || auto_exit) state_nx = GS_DRAIN;
      GS_DRAIN: state_nx = force_on_i ? GS_ON : busy_i ? GS_DRAIN : GS_OFF;
      default: state_nx = GS_OFF;
    endcase
    asleep_nx = (!req_i || (state == GS_OFF && wake_go)) ? 1'b0 : auto_exit ? 1'b1 : asleep;
    en_o = state != GS_OFF;
    ack_o = state == GS_ON;
    state_o = state;
  end
  always_ff @(posedge clk_inv_net or negedge arstn_i)
    if (!arstn_i) begin
      state <= GS_OFF;
      wake_cnt <= '0;
      asleep <= 1'b0;
    end else begin
      state <= state_nx;
      wake_cnt <= wake_cnt_nx;
      asleep <= asleep_nx;
    end
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed scenario bench for clk_gate_ctrl
module tb_clk_gate_ctrl;
  logic clk_inv_net = 1'b0;
  logic arstn_i, req_i, force_on_i, busy_i, en_o, ack_o;
  logic [7:0] idle_limit_i;
  logic [1:0] state_o;
  logic [3:0] obs, exp;
  int nvec = 0, nerr = 0;
  localparam logic [3:0] S_OFF = 4'b0000, S_WAKE = 4'b1001, S_ON = 4'b1110, S_DRAIN = 4'b1011;
  clk_gate_ctrl #(.WAKE_CYC(4), .IDLE_W(8)) dut (
    .clk_inv_net (clk_inv_net),
    .arstn_i     (arstn_i),
    .req_i       (req_i),
    .force_on_i  (force_on_i),
    .busy_i      (busy_i),
    .idle_limit_i(idle_limit_i),
    .en_o        (en_o),
    .ack_o       (ack_o),
    .state_o     (state_o)
  );
  always #5 clk_inv_net = ~clk_inv_net;
  assign obs = {en_o, ack_o, state_o};
  task automatic tick;
    @(posedge clk_inv_net);
    #1;
  endtask
  task automatic wake_up(input string nm);
    for (int k = 0; k < 5; k++) begin
      tick();
      exp = k < 4 ? S_WAKE : S_ON;
      nvec++;
      if (obs !== exp) begin nerr++; $display("FAIL %s[%0d] {en,ack,state} got %b want %b", nm, k, obs, exp); end
    end
  endtask
  task automatic test_reset;
    arstn_i = 1'b0; req_i = 1'b0; force_on_i = 1'b0; busy_i = 1'b0; idle_limit_i = 8'd0;
    #2;
    nvec++;
    if (obs !== S_OFF) begin nerr++; $display("FAIL reset_hold got %b want %b", obs, S_OFF); end
    req_i = 1'b1;
    tick(); tick();
    nvec++;
    if (obs !== S_OFF) begin nerr++; $display("FAIL reset_req got %b want %b", obs, S_OFF); end
    req_i = 1'b0;
    arstn_i = 1'b1;
    tick();
    nvec++;
    if (obs !== S_OFF) begin nerr++; $display("FAIL reset_idle got %b want %b", obs, S_OFF); end
  endtask
  task automatic test_wake;
    req_i = 1'b1;
    wake_up("wake");
  endtask
  task automatic test_manual_off;
    req_i = 1'b0; busy_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      nvec++;
      if (obs !== S_DRAIN) begin nerr++; $display("FAIL manual_drain[%0d] got %b want %b", k, obs, S_DRAIN); end
    end
    busy_i = 1'b0;
    tick();
    nvec++;
    if (obs !== S_OFF) begin nerr++; $display("FAIL manual_off got %b want %b", obs, S_OFF); end
  endtask
  task automatic test_auto_gate;
    req_i = 1'b1; busy_i = 1'b0; idle_limit_i = 8'd5;
    wake_up("auto_wake");
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp = k < 5 ? S_ON : S_DRAIN;
      nvec++;
      if (obs !== exp) begin nerr++; $display("FAIL auto_idle[%0d] got %b want %b", k, obs, exp); end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      nvec++;
      if (obs !== S_OFF) begin nerr++; $display("FAIL auto_asleep[%0d] got %b want %b", k, obs, S_OFF); end
    end
    nvec++;
    if (dut.asleep !== 1'b1) begin nerr++; $display("FAIL auto_asleep_flag got %b want 1", dut.asleep); end
    busy_i = 1'b1;
    tick();
    busy_i = 1'b0;
    nvec++;
    if (obs !== S_WAKE) begin nerr++; $display("FAIL auto_busy_wake got %b want %b", obs, S_WAKE); end
    nvec++;
    if (dut.asleep !== 1'b0) begin nerr++; $display("FAIL auto_asleep_clr got %b want 0", dut.asleep); end
    tick(); tick(); tick(); tick();
    nvec++;
    if (obs !== S_ON) begin nerr++; $display("FAIL auto_rewake got %b want %b", obs, S_ON); end
    tick(); tick();
    idle_limit_i = 8'd3;
    tick();
    nvec++;
    if (obs !== S_DRAIN) begin nerr++; $display("FAIL limit_change got %b want %b", obs, S_DRAIN); end
    tick();
    req_i = 1'b0;
    tick();
    nvec++;
    if (dut.asleep !== 1'b0) begin nerr++; $display("FAIL req_low_clr got %b want 0", dut.asleep); end
  endtask
  task automatic test_force_on;
    force_on_i = 1'b1; idle_limit_i = 8'd2; busy_i = 1'b0; req_i = 1'b0;
    wake_up("force_wake");
    for (int k = 0; k < 20; k++) begin
      tick();
      nvec++;
      if (obs !== S_ON) begin nerr++; $display("FAIL force_hold[%0d] got %b want %b", k, obs, S_ON); end
    end
    force_on_i = 1'b0; busy_i = 1'b1;
    tick();
    nvec++;
    if (obs !== S_DRAIN) begin nerr++; $display("FAIL force_to_drain got %b want %b", obs, S_DRAIN); end
    force_on_i = 1'b1;
    tick();
    nvec++;
    if (obs !== S_ON) begin nerr++; $display("FAIL force_drain_on got %b want %b", obs, S_ON); end
    force_on_i = 1'b0; busy_i = 1'b0;
    tick(); tick();
    nvec++;
    if (obs !== S_OFF) begin nerr++; $display("FAIL force_release got %b want %b", obs, S_OFF); end
  endtask
  task automatic test_async_reset;
    req_i = 1'b1; busy_i = 1'b0; idle_limit_i = 8'd0;
    tick(); tick();
    nvec++;
    if (dut.wake_cnt !== 8'd2) begin nerr++; $display("FAIL mid_wake_cnt got %0d want 2", dut.wake_cnt); end
    #2 arstn_i = 1'b0;
    #1;
    nvec++;
    if (obs !== S_OFF) begin nerr++; $display("FAIL arst_wake got %b want %b", obs, S_OFF); end
    nvec++;
    if (dut.wake_cnt !== 8'd0) begin nerr++; $display("FAIL arst_wake_cnt got %0d want 0", dut.wake_cnt); end
    arstn_i = 1'b1;
    wake_up("arst_rewake");
    tick(); tick();
    #2 arstn_i = 1'b0;
    #1;
    nvec++;
    if (obs !== S_OFF) begin nerr++; $display("FAIL arst_on got %b want %b", obs, S_OFF); end
    nvec++;
    if (dut.u_idle.cnt !== 8'd0) begin nerr++; $display("FAIL arst_idle_cnt got %0d want 0", dut.u_idle.cnt); end
    arstn_i = 1'b1;
  endtask
  task automatic test_idle_zero;
    req_i = 1'b1; busy_i = 1'b0; idle_limit_i = 8'd0;
    wake_up("zero_wake");
    for (int k = 1; k <= 300; k++) begin
      tick();
      nvec++;
      if (obs !== S_ON) begin nerr++; $display("FAIL zero_on[%0d] got %b want %b", k, obs, S_ON); end
      if (k == 254 || k == 300) begin
        nvec++;
        if (dut.u_idle.cnt !== (k == 254 ? 8'd254 : 8'd255))
          begin nerr++; $display("FAIL zero_cnt[%0d] got %0d want %0d", k, dut.u_idle.cnt, k == 254 ? 254 : 255); end
      end
    end
  endtask
  task automatic test_both_exit;
    idle_limit_i = 8'd1; req_i = 1'b0; busy_i = 1'b0;
    tick();
    nvec++;
    if (obs !== S_DRAIN) begin nerr++; $display("FAIL both_drain got %b want %b", obs, S_DRAIN); end
    nvec++;
    if (dut.asleep !== 1'b0) begin nerr++; $display("FAIL both_asleep got %b want 0", dut.asleep); end
    tick();
    req_i = 1'b1;
    tick();
    nvec++;
    if (obs !== S_WAKE) begin nerr++; $display("FAIL both_rewake got %b want %b", obs, S_WAKE); end
  endtask
  initial begin
    test_reset();
    test_wake();
    test_manual_off();
    test_auto_gate();
    test_force_on();
    test_async_reset();
    arstn_i = 1'b0;
    #1 arstn_i = 1'b1;
    test_idle_zero();
    test_both_exit();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
